// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: HTRANS codes and the word offsets that the
// simple register-mapped slaves on this bus decode from HADDR[3:2].
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] WORD_DIGITS = 2'd0;
    localparam logic [1:0] WORD_DOTS   = 2'd1;
    localparam logic [1:0] WORD_CTRL   = 2'd2;
    localparam logic [1:0] WORD_STATUS = 2'd3;

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex nibble to seven-segment glyph, active-high, bit 0 = segment a.
module seg_hex_decoder (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = '0;
        case (hex_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
        endcase
    end

endmodule

// File: rtl/ahb_seven_seg.sv
// AHB-Lite slave scanning a 4-digit common-anode seven-segment display.
// Digit/dot writes land in shadow registers and are committed at frame wrap.
module ahb_seven_seg #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [3:0]  nDigit,
    output logic [7:0]  nSegment
);
    import ahb_pkg::*;

    localparam int unsigned     CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic             wr_en_q, rd_en_q;
    logic [1:0]       word_addr_q;
    logic [15:0]      shadow_digits_q, active_digits_q;
    logic [3:0]       shadow_dots_q, active_dots_q;
    logic             enable_q, pending_q;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       scan_idx_q, scan_idx_d;
    logic [3:0]       ndigit_q, ndigit_d;
    logic [7:0]       nsegment_q, nsegment_d;

    logic             scan_tick, frame_wrap, commit, shadow_wr;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_glyph;
    logic             unused_bus;

    assign unused_bus = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

    assign HREADYOUT  = 1'b1;
    assign scan_tick  = (scan_cnt_q == CNT_LAST);
    assign frame_wrap = scan_tick && (scan_idx_q == 2'd3);
    assign commit     = frame_wrap && pending_q;
    assign shadow_wr  = wr_en_q && ((word_addr_q == WORD_DIGITS) || (word_addr_q == WORD_DOTS));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            word_addr_q <= '0;
        end else if (HREADY && HSEL && (HTRANS != HTRANS_IDLE)) begin
            wr_en_q     <= HWRITE;
            rd_en_q     <= !HWRITE;
            word_addr_q <= HADDR[3:2];
        end else begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            word_addr_q <= '0;
        end
    end

    // Commit reads the pre-write shadow; a same-cycle shadow write keeps Pending set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            shadow_digits_q <= '0;
            shadow_dots_q   <= '0;
            active_digits_q <= '0;
            active_dots_q   <= '0;
            enable_q        <= 1'b0;
            pending_q       <= 1'b0;
        end else begin
            if (wr_en_q) begin
                case (word_addr_q)
                    WORD_DIGITS: shadow_digits_q <= HWDATA[15:0];
                    WORD_DOTS:   shadow_dots_q   <= HWDATA[3:0];
                    WORD_CTRL:   enable_q        <= HWDATA[0];
                    default:     ;
                endcase
            end
            if (commit) begin
                active_digits_q <= shadow_digits_q;
                active_dots_q   <= shadow_dots_q;
            end
            if (shadow_wr) begin
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_tick) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign cur_nibble = active_digits_q[{scan_idx_q, 2'b00} +: 4];

    seg_hex_decoder u_hex (
        .hex_i (cur_nibble),
        .seg_o (cur_glyph)
    );

    always_comb begin
        ndigit_d   = 4'hF;
        nsegment_d = 8'hFF;
        if (enable_q) begin
            ndigit_d   = ~(4'b0001 << scan_idx_q);
            nsegment_d = ~{active_dots_q[scan_idx_q], cur_glyph};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ndigit_q   <= 4'hF;
            nsegment_q <= 8'hFF;
        end else begin
            ndigit_q   <= ndigit_d;
            nsegment_q <= nsegment_d;
        end
    end

    assign nDigit   = ndigit_q;
    assign nSegment = nsegment_q;

    always_comb begin
        HRDATA = '0;
        if (rd_en_q) begin
            case (word_addr_q)
                WORD_DIGITS: HRDATA = {16'd0, shadow_digits_q};
                WORD_DOTS:   HRDATA = {28'd0, shadow_dots_q};
                WORD_CTRL:   HRDATA = {31'd0, enable_q};
                WORD_STATUS: HRDATA = {27'd0, scan_idx_q, 2'b00, pending_q};
                default:     HRDATA = '0;
            endcase
        end
    end

endmodule

// File: doc/ahb_seven_seg.md
# ahb_seven_seg

AHB-Lite slave driving a 4-digit, multiplexed, common-anode seven-segment display; it is the output counterpart of the button input slave on the same bus. The M0 writes hex digit values, decimal points and an enable bit. The block double-buffers them, committing at frame boundaries so the display never tears. It scans the digits autonomously with a programmable divider.

## Interface
- SCAN_DIV, 1000, HCLK cycles each digit is lit (≥2)
- HCLK  input  1  bus clock, all logic on rising edge
- HRESETn  input  1  asynchronous active-low reset
- HADDR  input  32  only [3:2] decoded
- HWDATA  input  32  write data, sampled in data phase
- HSIZE  input  3  ignored; word transfers only
- HTRANS  input  2  IDLE (2'b00) means no transfer
- HWRITE  input  1  1 = write
- HREADY  input  1  bus ready
- HSEL  input  1  slave select
- HRDATA  output  32  read data; 0 when not reading
- HREADYOUT  output  1  tied 1, zero wait states
- nDigit  output  4  active-low digit enables; bit 0 = rightmost digit
- nSegment  output  8  active-low segments; bits 0..6 = a..g, bit 7 = dp

## Operation
- Address phase: if HREADY && HSEL && HTRANS != IDLE, register write_enable=HWRITE, read_enable=!HWRITE, word_address=HADDR[3:2]; else clear all three.
- Register map (word offsets):
  - +0 ShadowDigits[15:0] R/W
  - +4 ShadowDots[3:0] R/W
  - +8 Control[0] Enable R/W, immediate, not shadowed
  - +C Status R only; {27'd0, ScanIndex[1:0], 2'b0, Pending}
- Writes to +C are ignored. Unused HWDATA bits are dropped; unused read bits return 0.
- A write to +0 or +4 updates the shadow register and sets Pending.
- Reads return shadow values, not active values. Reading has no side effects.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count, ScanIndex increments mod 4.
  - When ScanIndex wraps 3→0 and Pending=1: ActiveDigits←ShadowDigits, ActiveDots←ShadowDots, Pending←0.
- Simultaneous shadow write and commit: the commit copies the pre-write shadow, the shadow takes the new data, and Pending stays 1.
- Display:
  - Enable=0: nDigit=4'hF, nSegment=8'hFF. Scanning continues.
  - Enable=1: nDigit = ~(1<<ScanIndex).
  - nSegment = ~{ActiveDots[ScanIndex], hex7(ActiveDigits[4*ScanIndex+:4])}.
- hex7 uses the standard hex glyphs 0–F (active-high: 0=7'h3F, 1=7'h06, 8=7'h7F, A=7'h77, F=7'h71).

## Timing
- Reset values:
  - Shadow, active and Control registers 0; Pending 0; ScanIndex 0; scan_cnt 0.
  - nDigit=4'hF, nSegment=8'hFF; HRDATA=0.
- Write: HWDATA sampled in the data phase; the register holds the new value one cycle later.
- Read: HRDATA is combinational in the data phase from the registered word_address.
- Outputs: nDigit/nSegment are registered, one cycle after ScanIndex/Enable/active data change. A change of Enable is visible on the outputs 2 cycles after its write data phase.
- Commit latency:
  - ≤4·SCAN_DIV+1 cycles after the shadow write.
  - A write whose data phase coincides with the wrap cycle commits at the next wrap.
- Reset mid-scan: outputs blank immediately (asynchronous); scanning resumes at ScanIndex 0.

## Structure
- Shared package ahb_pkg: HTRANS code localparams (IDLE, BUSY, NONSEQ, SEQ) and word-offset localparams, shared with the other AHB slaves.
- Sub-module seg_hex_decoder: combinational 4-bit → 7-bit active-high glyph. Inversion happens in the parent.
- Parent holds the bus decode, register file, scan divider and output registers.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset: assert HRESETn low → nDigit=4'hF, nSegment=8'hFF, HRDATA=0; reads of +0/+4/+8/+C return 0.
- Write +8=1, +0=16'h1234, +4=4'b0001; run 2 frames → Status Pending 1→0 at the wrap. Digit 0 shows nSegment=~{1,7'h66} ("4."), digit 3 shows ~{0,7'h06} ("1"). Each digit is lit for 4 cycles in order 0,1,2,3.
- Write +0=16'hFFFF, then read +0 before the commit → 16'hFFFF while the display still shows the old digits, and Pending=1.
- Write +0 in the exact wrap cycle → the old shadow value is committed, Pending stays 1, and the new value is displayed after the following wrap.
- Write +8=0 mid-frame → 2 cycles later nDigit=4'hF. ScanIndex in Status keeps advancing; re-enabling resumes on the current ScanIndex.
- Drive HTRANS=IDLE with HSEL=1 and HWRITE=1 → no register changes. With HREADY=0 in the address phase → the transfer is ignored.
